// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings and the read-slave state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Per-beat address generator: tracks the current beat address, beat count
// and burst length. While idle it forwards the AR address straight through
// so the first beat can be read in the acceptance cycle.
module axi_rd_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,     // AR accepted this cycle
    input  logic                  ld_i,        // a beat is loaded into R this cycle
    input  logic                  active_i,    // burst in progress
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic                  ar_fixed_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, cur_addr, nxt_addr;
    logic [7:0]            cnt_q, cnt_d, len_q, len_d, cur_cnt, cur_len;
    logic                  fixed_q, fixed_d, cur_fixed;

    // Current-beat view: registers mid-burst, the AR channel on acceptance.
    always_comb begin
        cur_addr   = active_i ? addr_q  : ar_addr_i;
        cur_cnt    = active_i ? cnt_q   : 8'd0;
        cur_len    = active_i ? len_q   : ar_len_i;
        cur_fixed  = active_i ? fixed_q : ar_fixed_i;
        last_o     = (cur_cnt == cur_len);
        // INCR realigns after the (possibly unaligned) first beat.
        nxt_addr   = cur_fixed ? cur_addr
                               : ((cur_addr & ~ADDR_WIDTH'(3)) + ADDR_WIDTH'(4));
        mem_addr_o = active_i ? addr_q : (start_i ? ar_addr_i : '0);
    end

    // Next-state for the address/count/length registers.
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fixed_d = fixed_q;
        if (start_i) begin
            len_d   = ar_len_i;
            fixed_d = ar_fixed_i;
            addr_d  = ld_i ? nxt_addr : ar_addr_i;
            cnt_d   = ld_i ? 8'd1 : 8'd0;
        end else if (active_i && ld_i) begin
            addr_d  = nxt_addr;
            cnt_d   = cnt_q + 8'd1;
        end
    end

    // Burst tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fixed_q <= fixed_d;
        end
    end

endmodule

// File: rtl/axi_mem_rd_slave.sv
// AXI4 read-only slave in front of a combinational memory read port.
// Bursts are split into per-beat reads; read data is registered into the R
// channel and streamed under rready backpressure at up to one beat per cycle.
module axi_mem_rd_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Extra headroom so start + span never overflows in the range check.
    localparam int EW = ADDR_WIDTH + 11;
    localparam logic [EW-1:0] MEM_LIMIT = EW'(MEM_BYTES);

    rd_state_t state_q, state_d;
    logic      en_q;          // holds arready low until the first clock after reset
    logic      accept, active, r_free, ld, last;

    logic [ID_WIDTH-1:0]   id_q, id_d, cur_id;
    logic [1:0]            resp_q, resp_d, ar_resp, cur_resp;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d, rvalid_q, rvalid_d;
    logic [EW-1:0]         span, end_addr;

    assign active    = (state_q == BURST);
    assign s_arready = en_q && (state_q == IDLE);
    assign accept    = s_arvalid && s_arready;
    assign r_free    = !rvalid_q || s_rready;
    assign ld        = (accept || active) && r_free;

    assign s_rid    = rid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_rlast  = rlast_q;
    assign s_rvalid = rvalid_q;

    axi_rd_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept),
        .ld_i       (ld),
        .active_i   (active),
        .ar_addr_i  (s_araddr),
        .ar_len_i   (s_arlen),
        .ar_fixed_i (s_arburst == BURST_FIXED),
        .mem_addr_o (mem_addr),
        .last_o     (last)
    );

    // Response classification of the request on the AR channel.
    always_comb begin
        span     = (s_arburst == BURST_FIXED) ? EW'(4)
                                              : ((EW'(s_arlen) + EW'(1)) << 2);
        end_addr = EW'(s_araddr) + span;
        if (end_addr > MEM_LIMIT)
            ar_resp = RESP_DECERR;
        else if (s_arsize != SIZE_WORD || s_arburst == BURST_WRAP || s_arburst == 2'b11)
            ar_resp = RESP_SLVERR;
        else
            ar_resp = RESP_OKAY;
        cur_resp = active ? resp_q : ar_resp;
        cur_id   = active ? id_q   : s_arid;
    end

    // FSM next state, request latch and R register load.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        resp_d   = resp_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;
        case (state_q)
            IDLE:  if (accept && !(ld && last)) state_d = BURST;
            BURST: if (ld && last)              state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
        if (accept) begin
            id_d   = s_arid;
            resp_d = ar_resp;
        end
        if (ld) begin
            rid_d    = cur_id;
            rresp_d  = cur_resp;
            rdata_d  = (cur_resp == RESP_OKAY) ? mem_rdata : '0;
            rlast_d  = last;
            rvalid_d = 1'b1;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State, request and R-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            id_q     <= '0;
            resp_q   <= RESP_OKAY;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= 1'b1;
            id_q     <= id_d;
            resp_q   <= resp_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule
